// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch port
// (read-only) and the data port (read/write). Each access is latched in IDLE,
// holds the memory bus for MEM_LATENCY cycles in ACCESS, then returns a
// one-cycle acknowledge in RESP. Data has priority over fetch; a streak counter
// forces a fetch grant after MAX_DATA_STREAK consecutive data grants while
// fetch is waiting.
// Optional macro ARB_PERF_CNT_EN: when defined, perf_if_wait / perf_dm_wait
// count saturating stall cycles; when undefined they are tied to zero.
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MEM_LATENCY     = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_dm_wait
);

    localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                owner_dm_q, owner_dm_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                grant_dm;

    // Next-state: arbitration and latching in IDLE, latency count in ACCESS, ack in RESP
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        owner_dm_d = owner_dm_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        grant_dm   = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_req || if_req) begin
                    // Data wins unless fetch is waiting and the streak budget is used up
                    grant_dm   = dm_req && (!if_req || (streak_q < STREAK_MAX));
                    owner_dm_d = grant_dm;
                    cnt_d      = CNT_LOAD;
                    state_d    = ACCESS;
                    if (grant_dm) begin
                        we_d     = dm_we;
                        addr_d   = dm_addr;
                        wdata_d  = dm_wdata;
                        streak_d = if_req ? (streak_q + 1'b1) : '0;
                    end else begin
                        we_d     = 1'b0;
                        addr_d   = if_addr;
                        wdata_d  = '0;
                        streak_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_dm_q) dm_rdata_d = mem_rdata;
                        else            if_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latches and read-data registers; reset abandons any access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            streak_q   <= '0;
            owner_dm_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            owner_dm_q <= owner_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = (state_q == RESP) && !owner_dm_q;
    assign dm_ack    = (state_q == RESP) && owner_dm_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_f   = if_req && !if_ack;
    assign stall_m   = dm_req && !dm_ack;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_dm_q, perf_dm_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    // Wait-cycle counters advance on every stalled cycle and stick at all-ones
    always_comb begin
        perf_if_d = stall_f ? sat_inc(perf_if_q) : perf_if_q;
        perf_dm_d = stall_m ? sat_inc(perf_dm_q) : perf_dm_q;
    end

    // Perf counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_q <= '0;
            perf_dm_q <= '0;
        end else begin
            perf_if_q <= perf_if_d;
            perf_dm_q <= perf_dm_d;
        end
    end

    assign perf_if_wait = perf_if_q;
    assign perf_dm_wait = perf_dm_q;
`else
    assign perf_if_wait = '0;
    assign perf_dm_wait = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a memory model answers the bus, requester
// tasks push expected read data to per-port queues, and a negedge monitor pops
// and compares them on every acknowledge.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int L  = 2;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_ack, dm_req, dm_we, dm_ack;
    logic [AW-1:0] if_addr, dm_addr, mem_addr;
    logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
    logic          stall_f, stall_m, mem_en, mem_we;
    logic [31:0]   perf_if_wait, perf_dm_wait;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L), .MAX_DATA_STREAK(MS)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .perf_if_wait(perf_if_wait), .perf_dm_wait(perf_dm_wait)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model seen by the DUT
    bit [31:0] mem_arr [0:1023];
    bit        mem_vld [0:1023];
    // Reference copy maintained by the requester tasks
    bit [31:0] ref_arr [0:1023];
    bit        ref_vld [0:1023];

    function automatic logic [31:0] base_word(input logic [31:0] a);
        if (a == 32'h10)  return 32'hE3A0_0001;
        if (a == 32'h200) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_vld[a[11:2]] ? ref_arr[a[11:2]] : base_word(a);
    endfunction

    assign mem_rdata = mem_vld[mem_addr[11:2]] ? mem_arr[mem_addr[11:2]] : base_word(mem_addr);

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_arr[mem_addr[11:2]] <= mem_wdata;
            mem_vld[mem_addr[11:2]] <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] if_exp_q[$];
    logic [31:0] dm_exp_q[$];
    bit          ack_log[$];
    int if_ack_cyc, dm_ack_cyc;
    int overlap_cnt = 0, we_bad = 0, stall_f_bad = 0, stall_m_bad = 0, wdata_bad = 0;
    logic [31:0] dm_last = '0;

    // Scoreboard monitor: pops expected data on each acknowledge
    always @(negedge clk) begin
        if (if_ack && dm_ack) overlap_cnt++;
        if (mem_we && !mem_en) we_bad++;
        if (if_ack) begin
            if_ack_cyc = cyc;
            ack_log.push_back(1'b0);
            if (if_exp_q.size() == 0) chk("if_unexpected_ack", 32'd1, 32'd0);
            else chk("if_rdata", if_rdata, if_exp_q.pop_front());
        end
        if (dm_ack) begin
            dm_ack_cyc = cyc;
            ack_log.push_back(1'b1);
            if (dm_exp_q.size() == 0) chk("dm_unexpected_ack", 32'd1, 32'd0);
            else chk("dm_rdata", dm_rdata, dm_exp_q.pop_front());
        end
    end

    task automatic fetch_tx(input logic [31:0] a, output int waits, output int en_cyc,
                            output int addr_bad);
        bit done = 1'b0;
        waits = 0; en_cyc = 0; addr_bad = 0;
        if_addr = a;
        if_req  = 1'b1;
        if_exp_q.push_back(ref_word(a));
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (if_ack) begin
                done = 1'b1;
                if (stall_f) stall_f_bad++;
            end else begin
                waits++;
                if (!stall_f) stall_f_bad++;
                if (mem_en) begin
                    en_cyc++;
                    if (mem_addr != a) addr_bad++;
                end
            end
        end
        if (!done) chk("if_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic data_tx(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           output int we_cyc);
        bit done = 1'b0;
        we_cyc = 0;
        dm_we = we; dm_addr = a; dm_wdata = wd;
        dm_req = 1'b1;
        if (we) begin
            dm_exp_q.push_back(dm_last);
            ref_arr[a[11:2]] = wd;
            ref_vld[a[11:2]] = 1'b1;
        end else begin
            dm_last = ref_word(a);
            dm_exp_q.push_back(dm_last);
        end
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (dm_ack) begin
                done = 1'b1;
                if (stall_m) stall_m_bad++;
            end else begin
                if (!stall_m) stall_m_bad++;
                if (mem_we) begin
                    we_cyc++;
                    if (mem_wdata != wd || mem_addr != a) wdata_bad++;
                end
            end
        end
        if (!done) chk("dm_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        dm_req = 1'b0;
    endtask

    int w0, e0, a0, w1, e1, a1, wc0, wc1;
    bit found, done;
    bit exp_pat [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
        chk("rst_dm_ack", {31'd0, dm_ack}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_perf_if", perf_if_wait, 32'd0);
        chk("rst_perf_dm", perf_dm_wait, 32'd0);
        @(posedge clk); #1;

        // Fetch alone
        fetch_tx(32'h10, w0, e0, a0);
        chk("fetch_latency", w0, L + 1);
        chk("fetch_mem_en_cycles", e0, L);
        chk("fetch_mem_addr", a0, 0);

        // Simultaneous fetch and data read
        fork
            fetch_tx(32'h40, w0, e0, a0);
            data_tx(1'b0, 32'h200, 32'h0, wc0);
        join
        chk("dm_before_if", {31'd0, dm_ack_cyc < if_ack_cyc}, 32'd1);
        chk("ack_gap", if_ack_cyc - dm_ack_cyc, L + 2);

        // Data write then readback
        wdata_bad = 0;
        data_tx(1'b1, 32'h204, 32'h1234_5678, wc0);
        chk("write_mem_we_cycles", wc0, L);
        chk("write_bus_values", wdata_bad, 0);
        data_tx(1'b0, 32'h204, 32'h0, wc1);
        chk("read_no_mem_we", wc1, 0);

        // Streak limiter: fetch held, data re-requesting continuously
        ack_log.delete();
        fork
            begin
                for (int i = 0; i < 2; i++) fetch_tx(32'h80 + 32'(4 * i), w1, e1, a1);
            end
            begin
                for (int j = 0; j < 10; j++) data_tx(1'b0, 32'h300 + 32'(4 * j), 32'h0, wc1);
            end
        join
        chk("streak_log_len", ack_log.size(), 12);
        for (int i = 0; i < 12 && i < ack_log.size(); i++)
            chk($sformatf("grant_order_%0d", i), {31'd0, ack_log[i]}, {31'd0, exp_pat[i]});

        // Reset during the first ACCESS cycle, then the same fetch retried
        if_addr = 32'h20; if_req = 1'b1;
        if_exp_q.push_back(ref_word(32'h20));
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (mem_en) found = 1'b1;
        end
        chk("rst_reach_access", {31'd0, found}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("midrst_if_ack", {31'd0, if_ack}, 32'd0);
        reset = 1'b0;
        dm_last = '0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (if_ack) done = 1'b1;
        end
        chk("midrst_retry_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;

        // Perf counters after a clean reset
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        fork
            fetch_tx(32'h44, w0, e0, a0);
            data_tx(1'b0, 32'h208, 32'h0, wc0);
        join
`ifdef ARB_PERF_CNT_EN
        chk("perf_if_wait", perf_if_wait, 2 * L + 3);
        chk("perf_dm_wait", perf_dm_wait, L + 1);
`else
        chk("perf_if_wait_tied", perf_if_wait, 32'd0);
        chk("perf_dm_wait_tied", perf_dm_wait, 32'd0);
`endif

        repeat (2) @(posedge clk);
        chk("ack_overlap", overlap_cnt, 0);
        chk("mem_we_outside_access", we_bad, 0);
        chk("stall_f_behaviour", stall_f_bad, 0);
        chk("stall_m_behaviour", stall_m_bad, 0);
        chk("if_queue_drained", if_exp_q.size(), 0);
        chk("dm_queue_drained", dm_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction fetch port (read-only) and data memory port (read/write).
- Sequences each access: latch request, hold memory bus for a fixed latency, return data with a one-cycle acknowledge.
- Drives stall requests back to the Fetch and Memory stages while a requester waits.
- Data port has priority; a streak limiter prevents fetch starvation.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 2, cycles the memory bus is held per access; legal range >= 1
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is waiting; legal range >= 1

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  DATA_W  fetched word; registered
- dm_req  in  1  data request; held until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_ack  out  1  one-cycle completion pulse
- dm_rdata  out  DATA_W  read data; registered
- stall_f  out  1  if_req & ~if_ack
- stall_m  out  1  dm_req & ~dm_ack
- mem_en  out  1  memory bus active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid on the last ACCESS cycle
- perf_if_wait  out  32  fetch wait-cycle count (optional feature)
- perf_dm_wait  out  32  data wait-cycle count (optional feature)

Behaviour:
- The clock port is clk and the reset port is reset. There is one clock. Reset is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - mem_en, mem_we, if_ack and dm_ack are 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata are 0.
  - The latency counter, the streak counter and the perf counters are 0.
- FSM states are IDLE, ACCESS and RESP.
- IDLE: requests are sampled only in this state.
  - No request: remain in IDLE.
  - Otherwise select an owner using the grant rule below.
  - Register addr, we and wdata from the owner.
  - Load cnt = MEM_LATENCY-1 and move to ACCESS.
- Grant rule:
  - dm_req only: grant data.
  - if_req only: grant fetch.
  - Both requesting, streak < MAX_DATA_STREAK: grant data.
  - Both requesting, streak == MAX_DATA_STREAK: grant fetch.
  - Streak update: a data grant while if_req=1 increments streak. Any fetch grant clears streak. A data grant while if_req=0 clears streak.
- ACCESS:
  - mem_en=1, and mem_addr and mem_wdata are driven from registers.
  - mem_we = latched we; it is always 0 for the fetch owner.
  - cnt decrements each cycle.
  - When cnt==0: on a read, capture mem_rdata into the owner's rdata register, then move to RESP.
  - Writes leave dm_rdata unchanged.
- RESP:
  - mem_en=0 and mem_we=0.
  - The owner's ack=1 for exactly this cycle, then move to IDLE.
  - No arbitration happens in RESP.
  - The requester may drop or change req/addr on the edge ending the ack cycle.
- Latency: grant edge to ack = MEM_LATENCY+1 cycles. Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Stalls:
  - stall_f and stall_m are combinational from req and ack, and are 0 in the ack cycle.
  - The non-owner stays stalled for the whole transaction.
- Request inputs changing while owned: no effect, because the values were latched at grant.
- Reset mid-transaction:
  - The access is abandoned.
  - mem_en and mem_we are 0 from the cycle after the reset edge.
  - No ack is issued.
  - Requesters must re-present their requests.
- Acks are exclusive: if_ack and dm_ack are never 1 together. mem_we is never 1 outside ACCESS.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - perf_if_wait increments each cycle stall_f=1.
  - perf_dm_wait increments each cycle stall_m=1.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
  - Both clear on reset.
- Undefined: the perf ports remain present and are tied to 0, with no counter logic.

Test Plan:
- Fetch only, MEM_LATENCY=2, if_addr=0x10, mem_rdata=0xE3A00001 -> mem_en for 2 cycles with mem_addr=0x10; if_ack at grant+3; if_rdata=0xE3A00001; stall_f=1 until the ack cycle.
- Simultaneous if_req and dm_req (read 0x200 -> 0xDEADBEEF) -> data granted first; dm_ack then if_ack 4 cycles later; if_ack and dm_ack never overlap.
- Data write dm_we=1, addr 0x204, wdata 0x12345678 -> mem_we=1 only during the 2 ACCESS cycles; dm_rdata keeps its prior value; dm_ack pulses once.
- Fetch held with data re-requesting continuously, MAX_DATA_STREAK=4 -> exactly 4 data grants, then a fetch grant; streak reset to 0; the pattern repeats.
- Reset asserted during ACCESS cycle 1 -> next cycle: IDLE, mem_en=0, no ack; the same request then completes normally after reset drops.
- ARB_PERF_CNT_EN defined: fetch waits 9 cycles -> perf_if_wait=9. Undefined -> perf_if_wait stays 0.
